// File: rtl/fifo_pkg.sv
// Shared types and constants for the read-side FIFO drain stage.
package fifo_pkg;

  // Occupancy of the two-word output buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  // Cycles between an accepted pop and its data appearing on r_data.
  localparam int unsigned RD_LATENCY = 1;

  // Number of words the output buffer can hold.
  localparam int unsigned BUF_DEPTH  = 2;

  function automatic logic [1:0] buf_occ(input buf_state_e s);
    case (s)
      ST_ONE:  return 2'd1;
      ST_TWO:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO pop side plus the outgoing valid/ready stream of the drain stage.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  r_empty;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_inc;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  // master: the drain stage (pops the FIFO, drives the stream)
  modport master (
    input  r_empty, r_data, m_ready,
    output r_inc, m_valid, m_data
  );

  // slave: the FIFO plus the downstream consumer
  modport slave (
    output r_empty, r_data, m_ready,
    input  r_inc, m_valid, m_data
  );
endinterface

// File: rtl/fifo_skid_buf.sv
// Two-word output buffer. The head register feeds the stream directly;
// the tail catches a word that lands while the head is still waiting.
//   state    | meaning
//   ST_EMPTY | no word held, stream idle
//   ST_ONE   | head valid
//   ST_TWO   | head and tail valid, no room for another write
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  deq,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head
);

  buf_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  // State and data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Next state and buffer moves; flush drops everything, including a word landing now.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (wr) begin
          state_d = ST_ONE;
          head_d  = wr_data;
        end
      end
      ST_ONE: begin
        if (wr && !deq) begin
          state_d = ST_TWO;
          tail_d  = wr_data;
        end else if (!wr && deq) begin
          state_d = ST_EMPTY;
        end else if (wr && deq) begin
          head_d  = wr_data;
        end
      end
      ST_TWO: begin
        if (deq) begin
          head_d = tail_q;
          if (wr) tail_d  = wr_data;
          else    state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  assign occ  = buf_occ(state_q);
  assign head = head_q;

  // The pop rule never lets a word land in a full buffer unless the head leaves.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(state_q == ST_TWO && wr && !deq));

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the async FIFO read port into a full-throughput valid/ready stream,
// counting delivered words. The pop decision reserves buffer room for the
// word still in the memory read pipeline.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  fifo_rd_stream_if.master     bus,
  input  logic                 flush,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic                 busy
);

  logic                  inflight;
  logic                  deq;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head;
  logic [2:0]            committed;

  assign deq       = bus.m_valid && bus.m_ready;
  // Words that will be held after this edge: buffered, minus leaving, plus landing.
  assign committed = 3'(occ) + 3'(inflight) - 3'(deq);
  assign bus.r_inc = !r_rst && !bus.r_empty && !flush && (committed < 3'(BUF_DEPTH));

  // A pop issued this cycle returns data next cycle.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) inflight <= 1'b0;
    else       inflight <= bus.r_inc;
  end

  fifo_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk    (r_clk),
    .rst    (r_rst),
    .flush  (flush),
    .wr     (inflight),
    .wr_data(bus.r_data),
    .deq    (deq),
    .occ    (occ),
    .head   (head)
  );

  assign bus.m_valid = (occ != 2'd0);
  assign bus.m_data  = head;
  assign busy        = (occ != 2'd0) || inflight;

  // Delivered-word counter; a handshake coinciding with flush is not counted.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst)      word_cnt <= '0;
    else if (flush) word_cnt <= '0;
    else if (deq)   word_cnt <= word_cnt + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for the FIFO drain stage: emulated FIFO source, queue-based model of
// the buffered stream, table-driven streaming run, directed corner cases and
// a randomized run.
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          r_clk = 1'b0;
  logic          r_rst;
  logic          flush;
  logic [CW-1:0] word_cnt;
  logic          busy;

  fifo_rd_stream_if #(.DATA_WIDTH(DW)) bus ();

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .r_clk   (r_clk),
    .r_rst   (r_rst),
    .bus     (bus),
    .flush   (flush),
    .word_cnt(word_cnt),
    .busy    (busy)
  );

  always #5 r_clk = ~r_clk;

  int n_vec  = 0;
  int n_err  = 0;
  int n_pops = 0;
  int mdl_cnt = 0;

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] mdl_buf[$];
  logic [DW-1:0] mdl_infl[$];
  logic [DW-1:0] delivered[$];

  logic          s_inc, s_valid, s_busy;
  logic [DW-1:0] s_data;
  logic [CW-1:0] s_cnt;

  typedef struct {
    logic          rdy;
    logic          inc;
    logic          valid;
    logic [DW-1:0] data;
    logic [CW-1:0] cnt;
    logic          bsy;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_delivered(input string name, input logic [DW-1:0] exp[$]);
    chk({name, "_count"}, 32'(delivered.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < delivered.size(); i++)
      chk({name, "_word"}, 32'(delivered[i]), 32'(exp[i]));
  endtask

  // One clock: drive inputs, sample at negedge, compare to model, advance model at posedge.
  task automatic cycle(input logic rdy, input logic fl, input logic force_e);
    logic          e_valid, e_deq, e_inc;
    logic [DW-1:0] w;
    bus.m_ready = rdy;
    flush       = fl;
    bus.r_empty = force_e || (src_q.size() == 0);
    @(negedge r_clk);
    s_inc   = bus.r_inc;
    s_valid = bus.m_valid;
    s_data  = bus.m_data;
    s_cnt   = word_cnt;
    s_busy  = busy;
    e_valid = (mdl_buf.size() != 0);
    e_deq   = e_valid && rdy;
    e_inc   = !bus.r_empty && !fl &&
              ((int'(mdl_buf.size()) - int'(e_deq) + int'(mdl_infl.size())) < 2);
    chk("r_inc", 32'(s_inc), 32'(e_inc));
    chk("m_valid", 32'(s_valid), 32'(e_valid));
    if (e_valid) chk("m_data", 32'(s_data), 32'(mdl_buf[0]));
    chk("word_cnt", 32'(s_cnt), 32'(mdl_cnt));
    chk("busy", 32'(s_busy), 32'(e_valid || (mdl_infl.size() != 0)));
    @(posedge r_clk);
    #1;
    if (s_valid && rdy) delivered.push_back(s_data);
    if (e_deq) void'(mdl_buf.pop_front());
    if (mdl_infl.size() != 0) begin
      w = mdl_infl.pop_front();
      if (!fl) mdl_buf.push_back(w);
    end
    if (fl) begin
      mdl_buf.delete();
      mdl_cnt = 0;
    end else if (e_deq) begin
      mdl_cnt = (mdl_cnt + 1) % (1 << CW);
    end
    if (s_inc && src_q.size() != 0) begin
      w = src_q.pop_front();
      bus.r_data = w;
      mdl_infl.push_back(w);
      n_pops++;
    end else begin
      bus.r_data = DW'($urandom_range(0, 255));
    end
  endtask

  task automatic reset_check(input string tag);
    bus.r_empty = (src_q.size() == 0);
    flush = 1'b0;
    r_rst = 1'b1;
    #1;
    chk({tag, "_r_inc"},    32'(bus.r_inc),   32'(0));
    chk({tag, "_m_valid"},  32'(bus.m_valid), 32'(0));
    chk({tag, "_m_data"},   32'(bus.m_data),  32'(0));
    chk({tag, "_word_cnt"}, 32'(word_cnt),    32'(0));
    chk({tag, "_busy"},     32'(busy),        32'(0));
    mdl_buf.delete();
    mdl_infl.delete();
    mdl_cnt = 0;
    @(posedge r_clk);
    #2;
    r_rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] exp_q[$];
    int            pops0;

    // Streaming table: 0x01..0x08 with m_ready held high, starting from empty.
    for (int c = 0; c < 11; c++) begin
      tbl[c].rdy   = 1'b1;
      tbl[c].inc   = (c < 8);
      tbl[c].valid = (c >= 2 && c <= 9);
      tbl[c].data  = (c >= 2 && c <= 9) ? DW'(c - 1) : '0;
      tbl[c].cnt   = (c < 3) ? '0 : CW'(c - 2);
      tbl[c].bsy   = (c >= 1 && c <= 9);
    end

    bus.r_empty = 1'b1;
    bus.r_data  = '0;
    bus.m_ready = 1'b0;
    flush       = 1'b0;
    r_rst       = 1'b0;
    reset_check("por");

    // Reset mid-stream: the in-flight 0x11 is lost, 0x22 follows.
    src_q = '{8'h11, 8'h22};
    delivered.delete();
    cycle(1'b1, 1'b0, 1'b0);
    reset_check("midrst");
    for (int c = 0; c < 4; c++) cycle(1'b1, 1'b0, 1'b0);
    exp_q = '{8'h22};
    chk_delivered("midrst_out", exp_q);

    // Streaming at full rate.
    reset_check("pre_stream");
    for (int i = 1; i <= 8; i++) src_q.push_back(DW'(i));
    delivered.delete();
    for (int c = 0; c < 11; c++) begin
      cycle(tbl[c].rdy, 1'b0, 1'b0);
      chk("tbl_r_inc", 32'(s_inc), 32'(tbl[c].inc));
      chk("tbl_m_valid", 32'(s_valid), 32'(tbl[c].valid));
      if (tbl[c].valid) chk("tbl_m_data", 32'(s_data), 32'(tbl[c].data));
      chk("tbl_word_cnt", 32'(s_cnt), 32'(tbl[c].cnt));
      chk("tbl_busy", 32'(s_busy), 32'(tbl[c].bsy));
    end

    // Backpressure: two pops fill the buffer, head held, then drain in order.
    src_q = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    delivered.delete();
    pops0 = n_pops;
    for (int c = 0; c < 5; c++) cycle(1'b0, 1'b0, 1'b0);
    chk("bp_pops", 32'(n_pops - pops0), 32'(2));
    chk("bp_r_inc", 32'(s_inc), 32'(0));
    chk("bp_m_valid", 32'(s_valid), 32'(1));
    chk("bp_m_data", 32'(s_data), 32'(8'hB1));
    chk("bp_state", 32'(dut.u_buf.state_q), 32'(ST_TWO));
    for (int c = 0; c < 7; c++) cycle(1'b1, 1'b0, 1'b0);
    exp_q = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    chk_delivered("bp_out", exp_q);

    // Empty flag toggling every cycle.
    src_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    delivered.delete();
    for (int c = 0; c < 16; c++) cycle(1'b1, 1'b0, (c % 2) == 0);
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    chk_delivered("empty_out", exp_q);

    // Flush while one word is buffered and another is in flight.
    delivered.delete();
    src_q = '{8'hC1};
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    src_q.push_back(8'hC2);
    cycle(1'b0, 1'b0, 1'b0);
    chk("fl_pre_pop", 32'(s_inc), 32'(1));
    chk("fl_pre_valid", 32'(s_valid), 32'(1));
    src_q.push_back(8'hC3);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("fl_m_valid", 32'(s_valid), 32'(0));
    chk("fl_word_cnt", 32'(s_cnt), 32'(0));
    chk("fl_busy", 32'(s_busy), 32'(0));
    for (int c = 0; c < 4; c++) cycle(1'b1, 1'b0, 1'b0);
    exp_q = '{8'hC3};
    chk_delivered("fl_out", exp_q);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0 && src_q.size() < 6)
        src_q.push_back(DW'($urandom_range(0, 255)));
      cycle($urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0);
    end

    // Counter wrap with a 4-bit counter: 17 words leave it at 1.
    reset_check("pre_wrap");
    src_q.delete();
    for (int i = 0; i < 17; i++) src_q.push_back(DW'(8'h40 + i));
    delivered.delete();
    for (int c = 0; c < 20; c++) cycle(1'b1, 1'b0, 1'b0);
    chk("wrap_word_cnt", 32'(word_cnt), 32'(1));
    chk("wrap_count", 32'(delivered.size()), 32'(17));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side drain stage that sits directly downstream of the async FIFO, in the read clock domain.
- Converts the FIFO pop interface (r_inc / r_empty / registered r_data) into a valid/ready stream with full throughput.
- Hides the one-cycle memory read latency with a 2-entry output buffer and in-flight tracking.
- Also counts delivered words and supports a synchronous flush.

Parameters:
DATA_WIDTH, 8, width of FIFO words and stream data
CNT_WIDTH, 16, width of delivered-word counter

Ports:
r_clk  input  1  read-domain clock; all logic on rising edge
r_rst  input  1  reset, asynchronous, active-high
r_empty  input  1  FIFO empty flag (read domain)
r_data  input  DATA_WIDTH  FIFO read data, valid the cycle after an accepted pop
r_inc  output  1  FIFO pop request
m_valid  output  1  stream data valid
m_data  output  DATA_WIDTH  stream data (head of buffer)
m_ready  input  1  downstream accepts when m_valid && m_ready
flush  input  1  synchronous clear of buffered/in-flight words
word_cnt  output  CNT_WIDTH  words delivered since reset/flush
busy  output  1  buffer non-empty or read in flight

Behaviour:
- Reset (r_rst high, async): r_inc=0, m_valid=0, m_data=0, word_cnt=0, busy=0, buffer occupancy=0, inflight=0. Reset may assert at any cycle; all state clears immediately, and any in-flight word is lost.
- Pop rule: r_inc = !r_empty && !flush && (occ + inflight + (inflight ? 0 : 0) < 2 after accounting the same-cycle dequeue), i.e. r_inc = !r_empty && !flush && (occ - deq + inflight) < 2, where deq = m_valid && m_ready.
- r_inc is combinational from registered state, r_empty and m_ready. It never asserts while r_empty=1.
- inflight register: set to r_inc each cycle (1-cycle read latency). When inflight=1, r_data is written into the buffer tail that cycle.
- Buffer: 2-entry FIFO of registers (head, tail) plus occ in {0,1,2}. Encode as FSM:
  - EMPTY: occ=0, m_valid=0.
  - ONE: occ=1, m_valid=1, m_data=head.
  - TWO: occ=2, m_valid=1, m_data=head.
- FSM transitions, with wr=inflight and deq as above:
  - EMPTY: wr → ONE.
  - ONE: wr&!deq → TWO; !wr&deq → EMPTY; wr&deq → ONE with head←r_data.
  - TWO: deq&!wr → ONE with head←tail; deq&wr → TWO with head←tail, tail←r_data. wr without deq in TWO is impossible by the pop rule; assert it never occurs.
- Latency: a word popped at edge N is visible on m_data at edge N+1 (m_valid high after N+1) when the buffer was EMPTY.
- Throughput: sustained 1 word/cycle when r_empty=0 and m_ready=1.
- m_data is held stable while m_valid && !m_ready. m_valid never drops without a handshake, except on flush or reset.
- word_cnt increments by 1 on each handshake. It wraps modulo 2^CNT_WIDTH, with no saturation.
- flush (sync, one cycle): next state EMPTY, inflight=0, word_cnt=0, r_inc forced 0 that cycle. A handshake in the flush cycle is still seen by downstream but is not counted. r_data arriving in the flush cycle is discarded.
- busy = (occ!=0) || inflight.

Decomposition:
- Package fifo_pkg: buffer state enum (ST_EMPTY, ST_ONE, ST_TWO) and constant RD_LATENCY=1.
- One natural sub-module: fifo_skid_buf (the 2-entry buffer + FSM, inputs wr/wr_data/deq, outputs occ/head).
- Pop logic and word counter stay in the top module.

Test Plan:
- Reset mid-stream: FIFO holds 0x11,0x22, m_ready=1, assert r_rst after the first pop → m_valid=0, word_cnt=0, r_inc=0 during reset; after release, pops resume from the FIFO's next word.
- Streaming: FIFO preloaded 0x01..0x08, m_ready=1 constant → r_inc high 8 consecutive cycles; m_data 0x01..0x08 on consecutive cycles starting one cycle after the first pop; word_cnt=8.
- Backpressure: 4 words, m_ready=0 → exactly 2 pops, then r_inc=0 with state TWO; m_data=first word held. Raise m_ready → all 4 words delivered in order with no loss or duplicates.
- Empty boundary: r_empty toggles 1/0 every cycle, data 0xA0.. → r_inc asserted only when r_empty=0; every popped word appears once, in order.
- Flush with in-flight read: state ONE, pop issued, flush next cycle → m_valid=0, word_cnt=0, busy=0 the cycle after; the discarded word never appears on m_data.
- Counter wrap (CNT_WIDTH=4): deliver 17 words → word_cnt reads 1.
